// File: rtl/vx_writeback_queue_if.sv
`default_nettype none
// ============================================================================
// Module   : vx_writeback_queue_if
// Purpose  : Bundles the eviction, DRAM request and snoop signals of the
//            dirty-line writeback queue.
//              master : bank / DRAM side (drives evict_*, dram_req_ready,
//                       snp_addr)
//              slave  : the writeback queue itself
// Ports    : evict_valid/addr/data/byteen/ready, fill_sent,
//            dram_req_valid/addr/data/byteen/ready, snp_addr, snp_hit, count
// Revision : 1.0 - initial release
// ============================================================================
interface vx_writeback_queue_if #(
    parameter int BANK_LINE_SIZE  = 16,
    parameter int LINE_ADDR_WIDTH = 26,
    parameter int QUEUE_SIZE      = 4
);
    localparam int c_lw    = BANK_LINE_SIZE * 8;
    localparam int c_cnt_w = $clog2(QUEUE_SIZE) + 1;

    logic                       evict_valid;
    logic [LINE_ADDR_WIDTH-1:0] evict_addr;
    logic [c_lw-1:0]            evict_data;
    logic [BANK_LINE_SIZE-1:0]  evict_byteen;
    logic                       evict_ready;
    logic                       fill_sent;

    logic                       dram_req_valid;
    logic [LINE_ADDR_WIDTH-1:0] dram_req_addr;
    logic [c_lw-1:0]            dram_req_data;
    logic [BANK_LINE_SIZE-1:0]  dram_req_byteen;
    logic                       dram_req_ready;

    logic [LINE_ADDR_WIDTH-1:0] snp_addr;
    logic                       snp_hit;
    logic [c_cnt_w-1:0]         count;

    modport master (
        output evict_valid, evict_addr, evict_data, evict_byteen,
        output dram_req_ready, snp_addr,
        input  evict_ready, fill_sent,
        input  dram_req_valid, dram_req_addr, dram_req_data, dram_req_byteen,
        input  snp_hit, count
    );

    modport slave (
        input  evict_valid, evict_addr, evict_data, evict_byteen,
        input  dram_req_ready, snp_addr,
        output evict_ready, fill_sent,
        output dram_req_valid, dram_req_addr, dram_req_data, dram_req_byteen,
        output snp_hit, count
    );
endinterface
`default_nettype wire

// File: rtl/vx_writeback_queue.sv
`default_nettype none
// ============================================================================
// Module   : vx_writeback_queue
// Purpose  : Dirty-line eviction buffer between the bank tag/data store and
//            the DRAM request port. Captures evicted lines, pulses fill_sent
//            on acceptance, drains entries in order under valid/ready and
//            offers an address snoop over pending writebacks.
// Ports    : clk, reset (synchronous, active-high)
//            bus (vx_writeback_queue_if.slave): evict_*, fill_sent,
//            dram_req_*, snp_addr, snp_hit, count
// Config   : VX_WB_BYTEEN_EN - store per-byte dirty masks and drop
//            evictions whose mask is all zero; otherwise byteen is all ones.
// Revision : 1.0 - initial release
// ============================================================================
module vx_writeback_queue #(
    parameter int BANK_LINE_SIZE  = 16,
    parameter int LINE_ADDR_WIDTH = 26,
    parameter int QUEUE_SIZE      = 4
) (
    input  logic                clk,
    input  logic                reset,
    vx_writeback_queue_if.slave bus
);
    localparam int c_lw    = BANK_LINE_SIZE * 8;
    localparam int c_idx_w = $clog2(QUEUE_SIZE);
    localparam int c_ptr_w = c_idx_w + 1;

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    logic [c_ptr_w-1:0]         r_wr_ptr;
    logic [c_ptr_w-1:0]         r_rd_ptr;
    logic [LINE_ADDR_WIDTH-1:0] r_addr [QUEUE_SIZE];
    logic [c_lw-1:0]            r_data [QUEUE_SIZE];

    logic [c_idx_w-1:0]         w_wr_idx;
    logic [c_idx_w-1:0]         w_rd_idx;
    logic [c_ptr_w-1:0]         w_count;
    logic                       w_full;
    logic                       w_empty;
    logic                       w_accept;
    logic                       w_push;
    logic                       w_pop;
    logic [QUEUE_SIZE-1:0]      w_match;

    assign w_wr_idx = r_wr_ptr[c_idx_w-1:0];
    assign w_rd_idx = r_rd_ptr[c_idx_w-1:0];
    assign w_count  = r_wr_ptr - r_rd_ptr;
    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    assign w_full   = (w_wr_idx == w_rd_idx) &&
                      (r_wr_ptr[c_idx_w] != r_rd_ptr[c_idx_w]);

    // Ready comes from registered pointers only; a pop in the same cycle
    // does not free a slot for a push when full.
    assign bus.evict_ready    = ~reset & ~w_full;
    assign w_accept           = bus.evict_valid & bus.evict_ready;
    assign bus.fill_sent      = w_accept;

    assign bus.dram_req_valid = ~reset & ~w_empty;
    assign w_pop              = bus.dram_req_valid & bus.dram_req_ready;

    assign bus.dram_req_addr  = r_addr[w_rd_idx];
    assign bus.dram_req_data  = r_data[w_rd_idx];
    assign bus.count          = w_count;

`ifdef VX_WB_BYTEEN_EN
    logic [BANK_LINE_SIZE-1:0] r_byteen [QUEUE_SIZE];

    // A line with no dirty bytes still clears its dirty state in the store,
    // but there is nothing worth writing back.
    assign w_push = w_accept & (|bus.evict_byteen);
    assign bus.dram_req_byteen = r_byteen[w_rd_idx];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_byteen[w_wr_idx] <= bus.evict_byteen;
        end
    end
`else
    logic w_unused_byteen;

    assign w_push              = w_accept;
    assign bus.dram_req_byteen = '1;
    assign w_unused_byteen     = ^bus.evict_byteen;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // Payload storage needs no reset: it is only observed when occupied.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[w_wr_idx] <= bus.evict_addr;
            r_data[w_wr_idx] <= bus.evict_data;
        end
    end

    // An entry is occupied when its distance from the read index is below the
    // occupancy count. The entry being pushed this cycle is not yet counted,
    // while the head being popped this cycle still is.
    for (genvar gi = 0; gi < QUEUE_SIZE; gi++) begin : g_snoop
        logic [c_idx_w-1:0] w_offset;
        assign w_offset    = c_idx_w'(gi) - w_rd_idx;
        assign w_match[gi] = ({1'b0, w_offset} < w_count) &&
                             (r_addr[gi] == bus.snp_addr);
    end

    assign bus.snp_hit = ~reset & (|w_match);

endmodule
`default_nettype wire

// File: tb/tb_vx_writeback_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_vx_writeback_queue
// Purpose  : Self-checking bench for vx_writeback_queue. A scoreboard queue
//            models queue contents; every cycle all outputs are compared with
//            values derived from that model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vx_writeback_queue;
    localparam int BANK_LINE_SIZE  = 16;
    localparam int LINE_ADDR_WIDTH = 26;
    localparam int QUEUE_SIZE      = 4;
    localparam int c_lw            = BANK_LINE_SIZE * 8;

    typedef struct packed {
        logic [LINE_ADDR_WIDTH-1:0] addr;
        logic [c_lw-1:0]            data;
        logic [BANK_LINE_SIZE-1:0]  byteen;
    } ent_t;

    logic clk;
    logic reset;
    int   checks;
    int   failures;
    ent_t sb[$];

    vx_writeback_queue_if #(
        .BANK_LINE_SIZE (BANK_LINE_SIZE),
        .LINE_ADDR_WIDTH(LINE_ADDR_WIDTH),
        .QUEUE_SIZE     (QUEUE_SIZE)
    ) bus ();

    vx_writeback_queue #(
        .BANK_LINE_SIZE (BANK_LINE_SIZE),
        .LINE_ADDR_WIDTH(LINE_ADDR_WIDTH),
        .QUEUE_SIZE     (QUEUE_SIZE)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [LINE_ADDR_WIDTH-1:0] a,
                         input logic [c_lw-1:0] d,
                         input logic [BANK_LINE_SIZE-1:0] be,
                         input logic rdy,
                         input logic [LINE_ADDR_WIDTH-1:0] snp);
        @(negedge clk);
        bus.evict_valid    = v;
        bus.evict_addr     = a;
        bus.evict_data     = d;
        bus.evict_byteen   = be;
        bus.dram_req_ready = rdy;
        bus.snp_addr       = snp;
    endtask

    // Compare every output against the model, then advance the model across
    // the next rising edge.
    task automatic step(input string tag);
        logic exp_ready, exp_valid, exp_hit, exp_fill, do_push;
        ent_t nxt;
        #2;
        exp_ready = !reset && (sb.size() < QUEUE_SIZE);
        exp_valid = !reset && (sb.size() > 0);
        exp_fill  = bus.evict_valid && exp_ready;
        exp_hit   = 1'b0;
        if (!reset) begin
            foreach (sb[i]) if (sb[i].addr == bus.snp_addr) exp_hit = 1'b1;
        end
        chk({tag, ".evict_ready"}, 128'(bus.evict_ready), 128'(exp_ready));
        chk({tag, ".fill_sent"},   128'(bus.fill_sent),   128'(exp_fill));
        chk({tag, ".dram_valid"},  128'(bus.dram_req_valid), 128'(exp_valid));
        chk({tag, ".snp_hit"},     128'(bus.snp_hit),     128'(exp_hit));
        if (!reset) begin
            chk({tag, ".count"}, 128'(bus.count), 128'(sb.size()));
        end
        if (exp_valid) begin
            chk({tag, ".head_addr"}, 128'(bus.dram_req_addr), 128'(sb[0].addr));
            chk({tag, ".head_data"}, bus.dram_req_data, sb[0].data);
`ifdef VX_WB_BYTEEN_EN
            chk({tag, ".head_byteen"}, 128'(bus.dram_req_byteen), 128'(sb[0].byteen));
`else
            chk({tag, ".head_byteen"}, 128'(bus.dram_req_byteen), 128'(16'hFFFF));
`endif
        end
`ifdef VX_WB_BYTEEN_EN
        do_push = exp_fill && (bus.evict_byteen != '0);
`else
        do_push = exp_fill;
`endif
        nxt.addr   = bus.evict_addr;
        nxt.data   = bus.evict_data;
        nxt.byteen = bus.evict_byteen;
        @(posedge clk);
        if (reset) begin
            sb.delete();
        end else begin
            if (exp_valid && bus.dram_req_ready) void'(sb.pop_front());
            if (do_push) sb.push_back(nxt);
        end
    endtask

    function automatic logic [c_lw-1:0] rnd_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        drive(1'b0, '0, '0, '0, 1'b0, '0);
        step("rst0");
        step("rst1");
        reset = 1'b0;

        // Single entry held until ready.
        drive(1'b1, 26'h123, {16{8'hA5}}, 16'hFFFF, 1'b0, 26'h3FF);
        step("single.push");
        drive(1'b0, '0, '0, '0, 1'b0, 26'h3FF);
        step("single.hold0");
        step("single.hold1");
        drive(1'b0, '0, '0, '0, 1'b1, 26'h3FF);
        step("single.pop");
        drive(1'b0, '0, '0, '0, 1'b0, 26'h3FF);
        step("single.empty");

        // Fill, refused 5th push, refused push alongside a pop.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 26'h10 + 26'(i), rnd_data(), 16'(16'h0F0F << i), 1'b0, 26'h3FF);
            step("full.push");
        end
        drive(1'b1, 26'h14, rnd_data(), 16'hFFFF, 1'b0, 26'h3FF);
        step("full.fifth");
        drive(1'b1, 26'h15, rnd_data(), 16'hFFFF, 1'b1, 26'h3FF);
        step("full.poppush");
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, '0, '0, '0, 1'b1, 26'h3FF);
            step("full.drain");
        end

        // Back-to-back stream with ready held high; pointers wrap.
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 26'h200 + 26'(i), rnd_data(), 16'hFFFF, 1'b1, 26'h3FF);
            step("stream");
        end
        drive(1'b0, '0, '0, '0, 1'b1, 26'h3FF);
        step("stream.tail");
        step("stream.idle");

        // Snoop, including the head being popped.
        drive(1'b1, 26'h40, rnd_data(), 16'hFFFF, 1'b0, 26'h3FF);
        step("snp.push40");
        drive(1'b1, 26'h41, rnd_data(), 16'hFFFF, 1'b0, 26'h41);
        step("snp.push41");
        drive(1'b0, '0, '0, '0, 1'b0, 26'h41);
        step("snp.hit41");
        drive(1'b0, '0, '0, '0, 1'b0, 26'h42);
        step("snp.miss42");
        drive(1'b0, '0, '0, '0, 1'b1, 26'h40);
        step("snp.popping40");
        step("snp.after40");
        step("snp.drained");

        // Zero byte mask.
        drive(1'b1, 26'h50, rnd_data(), 16'h0000, 1'b0, 26'h50);
        step("zero.push");
        drive(1'b0, '0, '0, '0, 1'b0, 26'h50);
        step("zero.after");
        drive(1'b0, '0, '0, '0, 1'b1, 26'h50);
        step("zero.drain");
        step("zero.idle");

        // Reset with three entries queued.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 26'h60 + 26'(i), rnd_data(), 16'hFFFF, 1'b0, 26'h61);
            step("mid.push");
        end
        drive(1'b0, '0, '0, '0, 1'b0, 26'h61);
        step("mid.queued");
        reset = 1'b1;
        step("mid.reset");
        reset = 1'b0;
        step("mid.after");
        drive(1'b1, 26'h70, rnd_data(), 16'hFFFF, 1'b1, 26'h61);
        step("mid.repush");
        drive(1'b0, '0, '0, '0, 1'b1, 26'h70);
        step("mid.reemit");
        step("mid.idle");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/vx_writeback_queue.md
# vx_writeback_queue

Dirty-line eviction buffer sitting directly downstream of the bank's tag/data store. When the bank pipe evicts a dirty line, this block captures the line address, the decoded (ECC-corrected) line data and the per-byte dirty mask, and pulses `fill_sent` so the store clears the line's dirty state. Queued lines are then drained to the DRAM request port under a valid/ready handshake. The block also offers an address snoop, so the bank can stall a miss to a line whose writeback is still pending.

## Interface
Parameters:
- `BANK_LINE_SIZE`, 16: line size in bytes. Data width is LW = `BANK_LINE_SIZE`*8.
- `LINE_ADDR_WIDTH`, 26: line address width ({tag, set}).
- `QUEUE_SIZE`, 4: number of entries; must be a power of 2 and ≥2.

Ports (clk is the clock; reset is synchronous and active-high):
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high
- `evict_valid`  in  1  bank presents a dirty line for writeback
- `evict_addr`  in  `LINE_ADDR_WIDTH`  line address
- `evict_data`  in  LW  decoded line data
- `evict_byteen`  in  `BANK_LINE_SIZE`  per-byte dirty mask (dirtyb)
- `evict_ready`  out  1  queue can accept; equals !full
- `fill_sent`  out  1  eviction accepted this cycle; drives the store's `fill_sent`
- `dram_req_valid`  out  1  head entry valid
- `dram_req_addr`  out  `LINE_ADDR_WIDTH`  head address
- `dram_req_data`  out  LW  head data
- `dram_req_byteen`  out  `BANK_LINE_SIZE`  head byte enables
- `dram_req_ready`  in  1  DRAM accepts the head
- `snp_addr`  in  `LINE_ADDR_WIDTH`  address to check for a pending writeback
- `snp_hit`  out  1  a queued entry matches `snp_addr`
- `count`  out  clog2(`QUEUE_SIZE`)+1  occupied entries

## Operation
- **Storage.** Circular FIFO with read and write pointers, each of clog2(`QUEUE_SIZE`)+1 bits, where the MSB is the wrap bit.
  - empty = pointers equal.
  - full = index bits equal and wrap bits differ.
- **Accept.** Accept = `evict_valid` & `evict_ready`. On accept:
  - `fill_sent`=1 in the same cycle (combinational).
  - The entry is written at the write pointer and the write pointer increments.
- **Drain.** Pop = `dram_req_valid` & `dram_req_ready`. On pop the read pointer increments.
- **Push and pop in the same cycle.** Both happen and `count` is unchanged.
- **Full.** When full, `evict_ready`=0 even if a pop occurs in the same cycle. There is no full-bypass.
- **Empty.** When empty, `dram_req_valid`=0. There is no empty-bypass: an entry pushed in cycle N is visible at the head in N+1.
- **DRAM handshake.**
  - Once `dram_req_valid`=1, it stays high, and addr/data/byteen stay stable, until a pop.
  - The valid does not depend combinationally on `dram_req_ready`.
- **Snoop.**
  - `snp_hit` = OR over all occupied entries of (entry addr == `snp_addr`), computed combinationally.
  - The head entry popped this cycle still counts as a hit (conservative).
  - An entry pushed this cycle does not count. The bank compares `evict_addr` itself.
- **Wrap-around.** Pointer arithmetic is modulo 2·`QUEUE_SIZE`. Indices use the low clog2(`QUEUE_SIZE`) bits.
- **Reset.**
  - Pointers = 0, `count`=0, `dram_req_valid`=0, `evict_ready`=0 while reset is high, `fill_sent`=0, `snp_hit`=0.
  - `dram_req_addr`/`data`/`byteen` are don't-care whenever `dram_req_valid`=0.
  - A reset asserted mid-operation discards all queued entries. No DRAM request is issued for them.

## Timing
- Latency from accept (cycle N) to `dram_req_valid` at the head of an empty queue: 1 cycle (N+1).
- Throughput: 1 accept and 1 pop per cycle sustained.
- `evict_ready`, `count` and `dram_req_valid` are derived from registered pointers only.
- Combinational paths:
  - `fill_sent` depends on `evict_valid`.
  - `snp_hit` depends on `snp_addr`.
- `evict_ready` goes to 1 in the first cycle after reset is deasserted.

## Configuration
- Macro: `VX_WB_BYTEEN_EN`.
- **Defined.**
  - `dram_req_byteen` carries the stored `evict_byteen`.
  - An accepted eviction with `evict_byteen`==0 still pulses `fill_sent`, but nothing is enqueued (pointers and `count` unchanged).
- **Undefined.**
  - Byte-enable storage is removed and `dram_req_byteen` is all ones.
  - Every accepted eviction is enqueued regardless of `evict_byteen`.

## Test plan
- **Single entry.** After reset, push addr 0x123 with data 0xA5…A5 and byteen 0xFFFF while `dram_req_ready`=0.
  - `fill_sent`=1 in the push cycle.
  - `dram_req_valid`=1 the next cycle with addr 0x123.
  - Valid and payload hold until ready=1; after the pop, `count` returns 0.
- **Full.** Push 4 lines (0x10–0x13) with ready=0.
  - `count`=4 and `evict_ready`=0.
  - A 5th `evict_valid` is not accepted and `fill_sent`=0.
  - A pop plus a push request in the same cycle: the push is refused.
- **Stream.** Hold ready=1 and push 10 lines back-to-back.
  - All 10 emerge in order, one per cycle, 1 cycle behind the pushes.
  - The pointers wrap twice and `count` stays ≤1.
- **Snoop.** Queue 0x40 and 0x41, then set `snp_addr`=0x41.
  - `snp_hit`=1; with 0x42, `snp_hit`=0.
  - With 0x40 in the cycle 0x40 pops, `snp_hit`=1; the next cycle it is 0.
- **Zero mask (`VX_WB_BYTEEN_EN`).** Push 0x50 with byteen 0x0000.
  - `fill_sent`=1 but `count` stays 0.
  - Without the macro, `count`=1 and byteen out is 0xFFFF.
- **Reset mid-run.** Assert reset with 3 entries queued.
  - The next cycle `count`=0, `dram_req_valid`=0 and `snp_hit`=0.
